bram_word_port: RTL



---
 rtl/bram_word_port_pkg.sv | 23 ++
 rtl/bram_word_port.sv | 122 ++++++++++++
 2 files changed

// File: rtl/bram_word_port_pkg.sv
// rtl/bram_word_port_pkg.sv - shared size encodings, FSM states and byte-count helper for bram_word_port
package bram_word_port_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // The reserved encoding (3) is treated as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_bytes = 3'd1;
      SIZE_HALF: size_to_bytes = 3'd2;
      default:   size_to_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bram_word_port.sv
// rtl/bram_word_port.sv - serialises byte/half/word requests into single-byte BRAM accesses
module bram_word_port
  import bram_word_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [7:0]            bram_din,
  output logic                  bram_wen,
  output logic                  bram_ren,
  input  logic [7:0]            bram_dout
);

  state_e                state_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [2:0]            n_q;
  logic [2:0]            idx_q;
  logic                  cap_en_q;
  logic [1:0]            lane_q;
  logic [31:0]           cap_q;
  logic [31:0]           cap_d;

  assign req_ready = (state_q == IDLE);

  // Read data lags ren by one cycle, so capture follows a delayed copy of bram_ren.
  always_comb begin
    cap_d = cap_q;
    if (cap_en_q) begin
      cap_d[{lane_q, 3'b000} +: 8] = bram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      cap_en_q  <= 1'b0;
      lane_q    <= '0;
      cap_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
      bram_wen  <= 1'b0;
      bram_ren  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      bram_wen  <= 1'b0;
      bram_ren  <= 1'b0;
      cap_en_q  <= bram_ren;
      if (cap_en_q) begin
        cap_q  <= cap_d;
        lane_q <= lane_q + 2'd1;
      end

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            base_q    <= req_addr;
            wdata_q   <= req_wdata;
            n_q       <= size_to_bytes(req_size);
            idx_q     <= 3'd1;
            cap_q     <= '0;
            lane_q    <= '0;
            bram_addr <= req_addr;
            bram_wen  <= req_write;
            bram_ren  <= !req_write;
            if (req_write) begin
              bram_din <= req_wdata[7:0];
            end
            state_q <= ISSUE;
          end
        end

        ISSUE: begin
          if (idx_q == n_q) begin
            if (write_q) begin
              rsp_valid <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            bram_addr <= base_q + ADDR_WIDTH'(idx_q);
            bram_wen  <= write_q;
            bram_ren  <= !write_q;
            if (write_q) begin
              bram_din <= wdata_q[{idx_q[1:0], 3'b000} +: 8];
            end
            idx_q <= idx_q + 3'd1;
          end
        end

        DRAIN: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= cap_d;
          state_q   <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
